cpu_pirq_err_regs: RTL and testbench



---
 rtl/cpu_pirq_err_regs.sv | 148 ++++++++++++++
 tb/tb_cpu_pirq_err_regs.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_pirq_err_regs.sv
// CPU register-window slave: PIR with request/ack handshake and CER/EAR error capture.
// Optional CPU_ERR_IRQ_EN adds the CER[15] enable bit and the err_irq_o interrupt.
module cpu_pirq_err_regs #(
  parameter int unsigned NLEVELS    = 7,
  parameter int unsigned NERR       = 6,
  parameter logic [8:0]  PIR_VECTOR = 9'o240,
  parameter int unsigned EADDR_W    = 22
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [2:0]         wb_adr_i,
  input  logic [15:0]        wb_dat_i,
  output logic [15:0]        wb_dat_o,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [1:0]         wb_sel_i,
  output logic               wb_ack_o,
  input  logic [2:0]         psw_pri_i,
  output logic               irq_o,
  input  logic               irq_ack_i,
  output logic [2:0]         irq_pri_o,
  output logic [8:0]         vector_o,
  input  logic [NERR-1:0]    err_i,
  input  logic [EADDR_W-1:0] err_addr_i,
  output logic               err_irq_o
);

  localparam logic [1:0] SEL_PIR    = 2'd0;
  localparam logic [1:0] SEL_CER    = 2'd1;
  localparam logic [1:0] SEL_EAR_LO = 2'd2;
  localparam logic [1:0] SEL_EAR_HI = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} irq_state_e;

  irq_state_e          state_q, state_d;
  logic [2:0]          irq_pri_d;
  logic [NLEVELS-1:0]  pir_req_q;
  logic [2:0]          pia_q, pia_c;
  logic [NERR-1:0]     err_q, err_clr_c, err_nxt_c;
  logic [EADDR_W-1:0]  ear_q;
  logic                lock_q;
  logic                cer_en;
  logic                acc_c, wr_c, pir_wr_c, cer_wr_c;
  logic [15:0]         rd_c;

  assign vector_o  = PIR_VECTOR;
  assign acc_c     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_c      = acc_c & wb_we_i;
  assign pir_wr_c  = wr_c & (wb_adr_i[2:1] == SEL_PIR) & wb_sel_i[1];
  assign cer_wr_c  = wr_c & (wb_adr_i[2:1] == SEL_CER);
  assign err_clr_c = (cer_wr_c & wb_sel_i[0]) ? wb_dat_i[NERR+1:2] : '0;
  // A new error pulse wins over a simultaneous write-one-to-clear.
  assign err_nxt_c = (err_q & ~err_clr_c) | err_i;

  // Highest pending PIR level
  always_comb begin
    pia_c = 3'd0;
    for (int k = 0; k < int'(NLEVELS); k++) begin
      if (pir_req_q[k]) pia_c = 3'(k + 1);
    end
  end

  always_comb begin
    rd_c = 16'd0;
    case (wb_adr_i[2:1])
      SEL_PIR:    rd_c = 16'({pir_req_q, 9'd0}) | {8'd0, pia_q, 1'b0, pia_q, 1'b0};
      SEL_CER:    rd_c = {cer_en, 15'({err_q, 2'b00})};
      SEL_EAR_LO: rd_c = ear_q[15:0];
      SEL_EAR_HI: rd_c = 16'(ear_q[EADDR_W-1:16]);
      default:    rd_c = 16'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 16'd0;
      pir_req_q <= '0;
      pia_q     <= 3'd0;
      err_q     <= '0;
      ear_q     <= '0;
      lock_q    <= 1'b0;
    end else begin
      wb_ack_o <= acc_c;
      wb_dat_o <= acc_c ? rd_c : 16'd0;
      pia_q    <= pia_c;
      if (pir_wr_c) pir_req_q <= wb_dat_i[8+NLEVELS:9];
      err_q <= err_nxt_c;
      // First error after the lock is released captures the address.
      if ((|err_i) && !lock_q) begin
        ear_q  <= err_addr_i;
        lock_q <= 1'b1;
      end else if (cer_wr_c && wb_sel_i[0] && (err_nxt_c == '0)) begin
        lock_q <= 1'b0;
      end
    end
  end

  // Interrupt request/acknowledge handshake
  always_comb begin
    state_d   = state_q;
    irq_pri_d = irq_pri_o;
    case (state_q)
      IDLE: if (pia_q > psw_pri_i) begin
        state_d   = REQ;
        irq_pri_d = pia_q;
      end
      REQ: begin
        if (irq_ack_i)                                      state_d = HOLD;
        else if ((pia_q != irq_pri_o) || (pia_q <= psw_pri_i)) state_d = IDLE;
      end
      HOLD: if (!irq_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      irq_o     <= 1'b0;
      irq_pri_o <= 3'd0;
    end else begin
      state_q   <= state_d;
      irq_o     <= (state_d == REQ);
      irq_pri_o <= irq_pri_d;
    end
  end

`ifdef CPU_ERR_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cer_en    <= 1'b0;
      err_irq_o <= 1'b0;
    end else begin
      if (cer_wr_c && wb_sel_i[1]) cer_en <= wb_dat_i[15];
      err_irq_o <= cer_en & (|err_nxt_c);
    end
  end
`else
  assign cer_en    = 1'b0;
  assign err_irq_o = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[0], wb_dat_i, wb_sel_i};

endmodule

// File: tb/tb_cpu_pirq_err_regs.sv
// Directed bench for cpu_pirq_err_regs: register table plus handshake and error sequences.
module tb_cpu_pirq_err_regs;

  localparam int unsigned NERR    = 6;
  localparam int unsigned EADDR_W = 22;
  localparam logic [2:0] A_PIR = 3'd0, A_CER = 3'd2, A_EARLO = 3'd4, A_EARHI = 3'd6;

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_i;
  logic [2:0]         wb_adr_i;
  logic [15:0]        wb_dat_i, wb_dat_o;
  logic               wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [1:0]         wb_sel_i;
  logic [2:0]         psw_pri_i, irq_pri_o;
  logic               irq_o, irq_ack_i, err_irq_o;
  logic [8:0]         vector_o;
  logic [NERR-1:0]    err_i;
  logic [EADDR_W-1:0] err_addr_i;

  int n_vec = 0;
  int n_err = 0;

  cpu_pirq_err_regs dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .psw_pri_i(psw_pri_i), .irq_o(irq_o),
    .irq_ack_i(irq_ack_i), .irq_pri_o(irq_pri_o), .vector_o(vector_o), .err_i(err_i),
    .err_addr_i(err_addr_i), .err_irq_o(err_irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic [15:0] exp_rd;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we, input logic [2:0] adr, input logic [15:0] dat,
                     input logic [1:0] sel, input logic [15:0] exp_rd, input string name);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.exp_rd = exp_rd; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'o%0o, expected 'o%0o", name, act, exp);
    end
  endtask

  // Single access starting at posedge+1; ep is driven as err_i during the access cycle.
  task automatic wb_acc(input logic we, input logic [2:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input logic [NERR-1:0] ep,
                        output logic [15:0] rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; err_i = ep;
    chk("ack_before_edge", 32'(wb_ack_o), 32'd0);
    @(posedge wb_clk_i); #1;
    chk("ack_after_1cyc", 32'(wb_ack_o), 32'd1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; err_i = '0;
    @(posedge wb_clk_i); #1;
    chk("ack_drop", 32'(wb_ack_o), 32'd0);
  endtask

  task automatic rd_chk(input logic [2:0] adr, input logic [15:0] exp, input string name);
    logic [15:0] rd;
    wb_acc(1'b0, adr, 16'd0, 2'b11, '0, rd);
    chk(name, 32'(rd), 32'(exp));
  endtask

  task automatic wr(input logic [2:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    logic [15:0] rd;
    wb_acc(1'b1, adr, dat, sel, '0, rd);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge wb_clk_i); #1; end
  endtask

  task automatic wait_irq(input logic exp, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (irq_o == exp) break;
      cyc(1);
    end
    chk(name, 32'(irq_o), 32'(exp));
  endtask

  task automatic irq_quiet(input int n, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (irq_o !== 1'b0) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  task automatic err_pulse(input logic [NERR-1:0] e, input logic [EADDR_W-1:0] a);
    err_i = e; err_addr_i = a;
    cyc(1);
    err_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cer_all_exp;
    wb_rst_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wb_we_i = 1'b0; wb_sel_i = '0; psw_pri_i = 3'd7; irq_ack_i = 1'b0;
    err_i = '0; err_addr_i = '0;
`ifdef CPU_ERR_IRQ_EN
    cer_all_exp = 16'o100000;
`else
    cer_all_exp = 16'o000000;
`endif

    add(0, A_PIR,   16'o0,      2'b11, 16'o0,      "rst_pir");
    add(0, A_CER,   16'o0,      2'b11, 16'o0,      "rst_cer");
    add(0, A_EARLO, 16'o0,      2'b11, 16'o0,      "rst_earlo");
    add(0, A_EARHI, 16'o0,      2'b11, 16'o0,      "rst_earhi");
    add(1, A_PIR,   16'o012000, 2'b10, 16'o0,      "wr_pir_l2l4");
    add(0, A_PIR,   16'o0,      2'b11, 16'o012210, "pir_l2l4");
    add(1, A_PIR,   16'o177777, 2'b01, 16'o0,      "wr_pir_even_only");
    add(0, A_PIR,   16'o0,      2'b11, 16'o012210, "pir_even_ignored");
    add(1, A_PIR,   16'o177777, 2'b11, 16'o0,      "wr_pir_all");
    add(0, A_PIR,   16'o0,      2'b11, 16'o177356, "pir_all");
    add(1, A_PIR,   16'o001000, 2'b10, 16'o0,      "wr_pir_l1");
    add(0, A_PIR,   16'o0,      2'b11, 16'o001042, "pir_l1");
    add(1, A_PIR,   16'o0,      2'b10, 16'o0,      "wr_pir_clr");
    add(0, A_PIR,   16'o0,      2'b11, 16'o0,      "pir_clr");
    add(1, A_EARLO, 16'o177777, 2'b11, 16'o0,      "wr_ear_ro");
    add(0, A_EARLO, 16'o0,      2'b11, 16'o0,      "ear_ro");
    add(1, A_CER,   16'o177777, 2'b11, 16'o0,      "wr_cer_all");
    add(0, A_CER,   16'o0,      2'b11, cer_all_exp, "cer_only_en");
    add(1, A_CER,   16'o0,      2'b11, 16'o0,      "wr_cer_zero");
    add(0, A_CER,   16'o0,      2'b11, 16'o0,      "cer_zero");

    cyc(3);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", 32'(wb_dat_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_pri", 32'(irq_pri_o), 32'd0);
    chk("vector", 32'(vector_o), 32'o240);
    wb_rst_i = 1'b0;
    cyc(1);

    for (int i = 0; i < tbl.size(); i++) begin
      logic [15:0] rd;
      wb_acc(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, '0, rd);
      if (!tbl[i].we) chk(tbl[i].name, 32'(rd), 32'(tbl[i].exp_rd));
    end

    // Request at level 4 over priority 3, ack with the core raising priority
    psw_pri_i = 3'd3;
    wr(A_PIR, 16'o012000, 2'b10);
    chk("irq_lag", 32'(irq_o), 32'd0);
    cyc(1);
    chk("irq_rise", 32'(irq_o), 32'd1);
    chk("irq_pri4", 32'(irq_pri_o), 32'd4);
    irq_ack_i = 1'b1; psw_pri_i = 3'd4;
    cyc(1);
    chk("irq_drop_on_ack", 32'(irq_o), 32'd0);
    irq_ack_i = 1'b0;
    irq_quiet(5, "no_rereq_pri_raised");
    wr(A_PIR, 16'o000000, 2'b10);
    psw_pri_i = 3'd3;
    irq_quiet(5, "no_rereq_bit_clr");

    // Pending level changes before ack: withdraw, then re-request at the new level
    wr(A_PIR, 16'o012000, 2'b10);
    wait_irq(1'b1, 6, "irq_l4_again");
    chk("irq_pri4_again", 32'(irq_pri_o), 32'd4);
    wr(A_PIR, 16'o032000, 2'b10);
    chk("irq_before_change", 32'(irq_o), 32'd1);
    cyc(1);
    chk("irq_withdraw_change", 32'(irq_o), 32'd0);
    cyc(1);
    chk("irq_rereq_l5", 32'(irq_o), 32'd1);
    chk("irq_pri5", 32'(irq_pri_o), 32'd5);

    // Priority raised to the pending level before ack
    psw_pri_i = 3'd5;
    cyc(1);
    chk("irq_withdraw_pri", 32'(irq_o), 32'd0);
    irq_quiet(3, "irq_idle_pri5");
    psw_pri_i = 3'd4;
    cyc(1);
    chk("irq_rereq_pri4", 32'(irq_o), 32'd1);

    // Reset while requesting
    wb_rst_i = 1'b1;
    cyc(1);
    chk("rst_req_irq", 32'(irq_o), 32'd0);
    chk("rst_req_pri", 32'(irq_pri_o), 32'd0);
    wb_rst_i = 1'b0; psw_pri_i = 3'd7;
    rd_chk(A_PIR, 16'o0, "rst_req_pir");

    // Error capture and lock
    err_pulse(6'b000010, 22'o1234567);
    err_pulse(6'b001000, 22'o7654321);
    rd_chk(A_CER,   16'o000050, "cer_two_err");
    rd_chk(A_EARLO, 16'o034567, "earlo_first");
    rd_chk(A_EARHI, 16'o000005, "earhi_first");
    chk("err_irq_gated", 32'(err_irq_o), 32'd0);
    wr(A_CER, 16'o000010, 2'b01);
    rd_chk(A_CER, 16'o000040, "cer_w1c_bit3");
    err_pulse(6'b000001, 22'o0000777);
    rd_chk(A_EARLO, 16'o034567, "ear_locked");
    rd_chk(A_CER, 16'o000044, "cer_after_locked_err");
    wr(A_CER, 16'o000044, 2'b01);
    rd_chk(A_CER, 16'o000000, "cer_cleared");
    err_pulse(6'b000100, 22'o7654321);
    rd_chk(A_EARLO, 16'o054321, "earlo_recapture");
    rd_chk(A_EARHI, 16'o000037, "earhi_recapture");
    rd_chk(A_CER,   16'o000020, "cer_bit4");

    // Set beats simultaneous W1C; lock must stay
    begin
      logic [15:0] rd;
      err_addr_i = 22'o0000777;
      wb_acc(1'b1, A_CER, 16'o000020, 2'b01, 6'b000100, rd);
    end
    rd_chk(A_CER, 16'o000020, "cer_set_wins");
    err_pulse(6'b000001, 22'o0001111);
    rd_chk(A_EARLO, 16'o054321, "lock_kept_set_wins");
    wr(A_CER, 16'o000024, 2'b01);
    rd_chk(A_CER, 16'o000000, "cer_final_clr");

`ifdef CPU_ERR_IRQ_EN
    wr(A_CER, 16'o100000, 2'b10);
    rd_chk(A_CER, 16'o100000, "cer_en_set");
    err_pulse(6'b000001, 22'o0);
    chk("err_irq_rise", 32'(err_irq_o), 32'd1);
    wr(A_CER, 16'o000004, 2'b01);
    chk("err_irq_drop", 32'(err_irq_o), 32'd0);
`else
    err_pulse(6'b000001, 22'o0);
    cyc(1);
    chk("err_irq_tied", 32'(err_irq_o), 32'd0);
    wr(A_CER, 16'o000004, 2'b01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
